// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types for the picoMIPS PC sequencer
package pc_seq_pkg;

  localparam int PSIZE_DEF = 6;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [PSIZE_DEF-1:0] match;
    logic [PSIZE_DEF-1:0] target;
  } redir_entry_t;

endpackage

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - register-array LIFO holding return addresses
module pc_ret_stack #(
  parameter int SDEPTH = 4,
  parameter int PSIZE  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [PSIZE-1:0] din,
  output logic [PSIZE-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = $clog2(SDEPTH + 1);
  localparam int AW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  logic [PSIZE-1:0] mem [SDEPTH];
  logic [CW-1:0]    count;

  assign empty     = (count == '0);
  assign full      = (count == CW'(SDEPTH));
  assign overflow  = push & full;
  assign underflow = pop & empty;
  // Only meaningful while not empty; the wrapped index is never consumed.
  assign top       = mem[AW'(count - CW'(1))];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      for (int i = 0; i < SDEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[AW'(count)] <= din;
      count           <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - picoMIPS program counter with redirect table, return stack and HALT
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PSIZE     = PSIZE_DEF,
  parameter int NREDIR    = 5,
  parameter int SDEPTH    = 4,
  parameter int HALT_ADDR = 2**PSIZE - 1,
  localparam int IW       = (NREDIR > 1) ? $clog2(NREDIR) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             incr,
  input  logic             relbranch,
  input  logic             absbranch,
  input  logic             call,
  input  logic             ret,
  input  logic             halt_req,
  input  logic             resume,
  input  logic [PSIZE-1:0] branch_addr,
  input  logic             redir_we,
  input  logic [IW-1:0]    redir_idx,
  input  logic [PSIZE-1:0] redir_match,
  input  logic [PSIZE-1:0] redir_target,
  input  logic             redir_clr,
  output logic [PSIZE-1:0] pc_out,
  output logic             halted,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam logic [PSIZE-1:0] HALT_PC = PSIZE'(HALT_ADDR);

  state_t           state;
  redir_entry_t     redir_tab [NREDIR];
  logic             hit;
  logic [PSIZE-1:0] hit_target;
  logic [PSIZE-1:0] addend;
  logic [PSIZE-1:0] sum;
  logic [PSIZE-1:0] stk_top;
  logic             run_go;
  logic             halt_go;
  logic             do_ret;
  logic             do_call;
  logic             stk_ovf;
  logic             stk_unf;

  // One adder: +1 for incr and for the call return address, +branch_addr otherwise.
  assign addend  = (incr | call) ? PSIZE'(1) : branch_addr;
  assign sum     = pc_out + addend;

  assign run_go  = en && (state == S_RUN);
  assign halt_go = (pc_out == HALT_PC) || halt_req;
  assign do_ret  = run_go && !halt_go && !hit && ret;
  assign do_call = run_go && !halt_go && !hit && !ret && call;

  always_comb begin
    hit        = 1'b0;
    hit_target = '0;
    for (int i = NREDIR - 1; i >= 0; i--) begin
      if (redir_tab[i].valid && redir_tab[i].match == pc_out) begin
        hit        = 1'b1;
        hit_target = redir_tab[i].target;
      end
    end
  end

  // Clear first so a same-cycle write survives the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREDIR; i++) redir_tab[i] <= '0;
    end else begin
      for (int i = 0; i < NREDIR; i++) begin
        if (redir_clr) redir_tab[i].valid <= 1'b0;
        if (redir_we && redir_idx == IW'(i)) begin
          redir_tab[i].valid  <= 1'b1;
          redir_tab[i].match  <= redir_match;
          redir_tab[i].target <= redir_target;
        end
      end
    end
  end

  pc_ret_stack #(
    .SDEPTH (SDEPTH),
    .PSIZE  (PSIZE)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (do_call),
    .pop       (do_ret),
    .din       (sum),
    .top       (stk_top),
    .empty     (stack_empty),
    .full      (stack_full),
    .overflow  (stk_ovf),
    .underflow (stk_unf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RUN;
      pc_out    <= '0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      if (stk_ovf || stk_unf) stack_err <= 1'b1;
      if (en) begin
        case (state)
          S_RUN: begin
            if (halt_go) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else if (hit) begin
              pc_out <= hit_target;
            end else if (ret) begin
              if (!stack_empty) pc_out <= stk_top;
            end else if (call) begin
              pc_out <= stack_full ? sum : branch_addr;
            end else if (incr || relbranch) begin
              pc_out <= sum;
            end else if (absbranch) begin
              pc_out <= branch_addr;
            end
          end
          S_HALT: begin
            if (resume) begin
              state  <= S_RUN;
              halted <= 1'b0;
              pc_out <= branch_addr;
            end
          end
          default: begin
            state  <= S_RUN;
            halted <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed checks of pc_sequencer
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, incr, relbranch, absbranch, call, ret, halt_req, resume;
  logic [5:0] branch_addr;
  logic       redir_we, redir_clr;
  logic [2:0] redir_idx;
  logic [5:0] redir_match, redir_target;
  logic [5:0] pc_out, pc_out62;
  logic       halted, stack_empty, stack_full, stack_err;
  logic       halted62, stack_empty62, stack_full62, stack_err62;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .en(en), .incr(incr), .relbranch(relbranch),
    .absbranch(absbranch), .call(call), .ret(ret), .halt_req(halt_req),
    .resume(resume), .branch_addr(branch_addr), .redir_we(redir_we),
    .redir_idx(redir_idx), .redir_match(redir_match), .redir_target(redir_target),
    .redir_clr(redir_clr), .pc_out(pc_out), .halted(halted),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  pc_sequencer #(.HALT_ADDR(62)) dut62 (
    .clk(clk), .reset(reset), .en(en), .incr(incr), .relbranch(relbranch),
    .absbranch(absbranch), .call(call), .ret(ret), .halt_req(halt_req),
    .resume(resume), .branch_addr(branch_addr), .redir_we(redir_we),
    .redir_idx(redir_idx), .redir_match(redir_match), .redir_target(redir_target),
    .redir_clr(redir_clr), .pc_out(pc_out62), .halted(halted62),
    .stack_empty(stack_empty62), .stack_full(stack_full62), .stack_err(stack_err62)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    en = 1'b1; incr = 1'b0; relbranch = 1'b0; absbranch = 1'b0;
    call = 1'b0; ret = 1'b0; halt_req = 1'b0; resume = 1'b0;
    redir_we = 1'b0; redir_clr = 1'b0;
  endtask

  task automatic jump(input logic [5:0] a);
    clr_in();
    absbranch = 1'b1; branch_addr = a;
    tick();
    absbranch = 1'b0;
  endtask

  task automatic wr_redir(input logic [2:0] idx, input logic [5:0] m, input logic [5:0] t);
    redir_we = 1'b1; redir_idx = idx; redir_match = m; redir_target = t;
    tick();
    redir_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clr_in();
    branch_addr = '0; redir_idx = '0; redir_match = '0; redir_target = '0;
    repeat (2) tick();
    chk("rst_pc", pc_out, 0);
    chk("rst_halted", halted, 0);
    chk("rst_empty", stack_empty, 1);
    chk("rst_full", stack_full, 0);
    chk("rst_err", stack_err, 0);
    reset = 1'b1;

    incr = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("incr_seq", pc_out, i);
    end

    // HALT_ADDR boundary on both instances
    jump(6'd62);
    chk("abs62", pc_out, 62);
    chk("h62_pre", halted62, 0);
    incr = 1'b1;
    tick();
    chk("pc63", pc_out, 63);
    chk("not_halt63", halted, 0);
    chk("h62_halted", halted62, 1);
    chk("h62_pc", pc_out62, 62);
    tick();
    chk("halt63", halted, 1);
    chk("halt63_pc", pc_out, 63);
    tick();
    chk("halt63_hold", pc_out, 63);
    clr_in();
    resume = 1'b1; branch_addr = 6'd4;
    tick();
    chk("resume_pc", pc_out, 4);
    chk("resume_run", halted, 0);
    resume = 1'b0;

    // redirect: lowest index wins, out-of-range index ignored
    wr_redir(3'd0, 6'd6, 6'd20);
    wr_redir(3'd1, 6'd6, 6'd30);
    wr_redir(3'd5, 6'd5, 6'd50);
    chk("redir_wr_hold", pc_out, 4);
    incr = 1'b1;
    tick(); chk("redir_seq5", pc_out, 5);
    tick(); chk("redir_seq6", pc_out, 6);
    tick(); chk("redir_hit", pc_out, 20);
    clr_in();
    redir_clr = 1'b1; absbranch = 1'b1; branch_addr = 6'd4;
    tick();
    clr_in();
    chk("clr_abs", pc_out, 4);
    incr = 1'b1;
    tick(); chk("clr_seq5", pc_out, 5);
    tick(); chk("clr_seq6", pc_out, 6);
    tick(); chk("clr_seq7", pc_out, 7);
    incr = 1'b0;

    // simultaneous write and clear
    wr_redir(3'd0, 6'd8, 6'd33);
    redir_clr = 1'b1;
    wr_redir(3'd2, 6'd9, 6'd44);
    redir_clr = 1'b0;
    incr = 1'b1;
    tick(); chk("weclr_8", pc_out, 8);
    tick(); chk("weclr_9", pc_out, 9);
    tick(); chk("weclr_hit", pc_out, 44);
    clr_in();
    redir_clr = 1'b1;
    tick();
    redir_clr = 1'b0;

    // relative branches, including wrap
    jump(6'd10);
    relbranch = 1'b1; branch_addr = 6'h3E;
    tick(); chk("rel_neg2", pc_out, 8);
    branch_addr = 6'd5;
    tick(); chk("rel_plus5", pc_out, 13);
    jump(6'd60);
    relbranch = 1'b1; branch_addr = 6'd10;
    tick(); chk("rel_wrap", pc_out, 6);
    relbranch = 1'b0;

    // call / return
    jump(6'd3);
    call = 1'b1; branch_addr = 6'd40;
    tick(); chk("call_pc", pc_out, 40);
    chk("call_nonempty", stack_empty, 0);
    call = 1'b0; ret = 1'b1;
    tick(); chk("ret_pc", pc_out, 4);
    chk("ret_empty", stack_empty, 1);
    ret = 1'b0; call = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      branch_addr = 6'(10 * i);
      tick();
      chk("call_n", pc_out, 10 * i);
    end
    chk("full4", stack_full, 1);
    chk("err_pre_ovf", stack_err, 0);
    branch_addr = 6'd50;
    tick();
    chk("ovf_pc", pc_out, 41);
    chk("ovf_err", stack_err, 1);
    chk("ovf_full", stack_full, 1);
    call = 1'b0; ret = 1'b1;
    tick(); chk("pop31", pc_out, 31);
    tick(); chk("pop21", pc_out, 21);
    tick(); chk("pop11", pc_out, 11);
    tick(); chk("pop5", pc_out, 5);
    chk("pop_empty", stack_empty, 1);
    ret = 1'b0;

    // halt_req, inputs ignored in HALT, resume needs en
    jump(6'd12);
    halt_req = 1'b1; incr = 1'b1;
    tick();
    chk("hreq_halted", halted, 1);
    chk("hreq_pc", pc_out, 12);
    halt_req = 1'b0; call = 1'b1; ret = 1'b1; branch_addr = 6'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_hold_pc", pc_out, 12);
    end
    chk("halt_hold_st", halted, 1);
    clr_in();
    en = 1'b0; resume = 1'b1; branch_addr = 6'd0;
    tick();
    chk("resume_en0", halted, 1);
    en = 1'b1;
    tick();
    chk("resume0_pc", pc_out, 0);
    chk("resume0_run", halted, 0);
    clr_in();

    // stall: PC frozen, redirect write still lands
    en = 1'b0; incr = 1'b1; halt_req = 1'b1;
    redir_we = 1'b1; redir_idx = 3'd3; redir_match = 6'd2; redir_target = 6'd50;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc_out, 0);
    end
    chk("stall_halt_ign", halted, 0);
    clr_in();
    incr = 1'b1;
    tick(); chk("post_stall1", pc_out, 1);
    tick(); chk("post_stall2", pc_out, 2);
    tick(); chk("stall_redir", pc_out, 50);

    // asynchronous reset in the middle of a call sequence
    clr_in();
    call = 1'b1; branch_addr = 6'd30;
    tick();
    chk("pre_rst_call", pc_out, 30);
    chk("pre_rst_nonempty", stack_empty, 0);
    branch_addr = 6'd20;
    #3 reset = 1'b0;
    #1;
    chk("async_rst_pc", pc_out, 0);
    chk("async_rst_empty", stack_empty, 1);
    chk("async_rst_err", stack_err, 0);
    clr_in();
    tick();
    reset = 1'b1;
    incr = 1'b1;
    tick(); chk("rst_redir1", pc_out, 1);
    tick(); chk("rst_redir2", pc_out, 2);
    tick(); chk("rst_redir_inv", pc_out, 3);
    clr_in();
    ret = 1'b1;
    tick();
    chk("unf_pc", pc_out, 3);
    chk("unf_err", stack_err, 1);
    ret = 1'b0;
    tick();
    chk("err_sticky", stack_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
